// File: rtl/wb_io_debug_pkg.sv
// Shared constants, slave FSM encoding and lane helper for the IO debug port.
// Latency: n/a (package).
// Backpressure: n/a (package).
package wb_io_debug_pkg;

    // Default IO port addresses
    localparam logic [15:0] POST_PORT_ADDR = 16'h0080;
    localparam logic [15:0] CON_PORT_ADDR  = 16'h00E9;

    // Value returned on lanes nobody drives, and the console port's read signature
    localparam logic [7:0]  FLOAT_BYTE     = 8'hFF;
    localparam logic [7:0]  CON_READ_BYTE  = 8'hE9;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_RESP       = 2'd2
    } slv_state_e;

    // Byte carried on a given Wishbone lane
    function automatic logic [7:0] lane_byte(input logic [31:0] dat, input logic [1:0] lane);
        return dat[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/wb_io_debug_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and occupancy level.
// Latency: pushed data visible at head (and in level/empty) the cycle after the push.
// Backpressure: push ignored when full unless a pop frees the slot in the same cycle.
module wb_io_debug_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates the full case from the empty case
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still legal
    assign do_push = push_i & (~full_o | do_pop);

    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = do_push ? wr_ptr_q + LW'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + LW'(1) : rd_ptr_q;

    // Pointer update; wrap is natural modulo 2*DEPTH
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/wb_io_debug_port.sv
// Wishbone classic IO slave: POST code port and debug console port with byte-stream FIFO.
// Latency: ack/err one cycle after the request is sampled, plus any time waiting for FIFO space.
// Backpressure: console writes into a full FIFO stall the bus until the consumer drains a byte.
// Optional macro WB_IO_DEBUG_PORT_ERR_EN: unmapped accesses end with wb_err_o instead of wb_ack_o.
module wb_io_debug_port
    import wb_io_debug_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] POST_PORT  = POST_PORT_ADDR,
    parameter logic [15:0] CON_PORT   = CON_PORT_ADDR,
    localparam int         LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic [31:0]   wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic [7:0]    con_data_o,
    output logic          con_valid_o,
    input  logic          con_ready_i,
    output logic [7:0]    post_code_o,
    output logic          post_stb_o,
    output logic [LW-1:0] con_level_o
);

`ifdef WB_IO_DEBUG_PORT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    slv_state_e    state_q;
    logic          ack_q;
    logic          err_q;
    logic [31:0]   dat_q;
    logic [7:0]    post_code_q;
    logic          post_stb_q;
    logic          post_pend_q;
    logic [7:0]    con_byte_q;

    logic          req;
    logic          post_word;
    logic          con_word;
    logic          post_hit;
    logic          con_hit;
    logic          no_hit;
    logic [7:0]    post_byte;
    logic [7:0]    con_byte;
    logic [31:0]   rd_dat;

    logic          fifo_push;
    logic [7:0]    fifo_push_dat;
    logic          fifo_full;
    logic          fifo_empty;

    // Cycle type, burst type and the upper address half carry no meaning for this slave
    logic          unused_inputs;
    assign unused_inputs = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:16], wb_adr_i[1:0]};

    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

    assign post_word = (wb_adr_i[15:2] == POST_PORT[15:2]);
    assign con_word  = (wb_adr_i[15:2] == CON_PORT[15:2]);
    assign post_hit  = post_word & wb_sel_i[POST_PORT[1:0]];
    assign con_hit   = con_word  & wb_sel_i[CON_PORT[1:0]];
    assign no_hit    = ~(post_hit | con_hit);

    assign post_byte = lane_byte(wb_dat_i, POST_PORT[1:0]);
    assign con_byte  = lane_byte(wb_dat_i, CON_PORT[1:0]);

    // Per-lane read data: port lanes return their value, everything else floats high
    always_comb begin
        rd_dat = '0;
        for (int n = 0; n < 4; n++) begin
            rd_dat[8*n +: 8] = FLOAT_BYTE;
            if (wb_sel_i[n] && con_word && (2'(n) == CON_PORT[1:0])) begin
                rd_dat[8*n +: 8] = CON_READ_BYTE;
            end else if (wb_sel_i[n] && post_word && (2'(n) == POST_PORT[1:0])) begin
                rd_dat[8*n +: 8] = post_code_q;
            end
        end
    end

    // Push straight from the bus in IDLE when there is room, or from the held byte once space frees up
    always_comb begin
        fifo_push     = 1'b0;
        fifo_push_dat = con_byte;
        if (state_q == ST_IDLE) begin
            fifo_push = req & wb_we_i & con_hit & ~fifo_full;
        end else if (state_q == ST_WAIT_SPACE) begin
            fifo_push     = wb_cyc_i & ~fifo_full;
            fifo_push_dat = con_byte_q;
        end
    end

    // Slave FSM with registered bus response and POST outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            post_code_q <= 8'h00;
            post_stb_q  <= 1'b0;
            post_pend_q <= 1'b0;
            con_byte_q  <= 8'h00;
        end else begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            post_stb_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (wb_we_i && post_hit) begin
                            post_code_q <= post_byte;
                        end
                        if (wb_we_i && con_hit && fifo_full) begin
                            // Hold the byte and the pending POST strobe until the FIFO has room
                            con_byte_q  <= con_byte;
                            post_pend_q <= post_hit;
                            state_q     <= ST_WAIT_SPACE;
                        end else begin
                            state_q    <= ST_RESP;
                            post_stb_q <= wb_we_i & post_hit;
                            dat_q      <= wb_we_i ? 32'h0 : rd_dat;
                            if (ERR_EN && no_hit) begin
                                err_q <= 1'b1;
                            end else begin
                                ack_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT_SPACE: begin
                    if (!wb_cyc_i) begin
                        // Master abandoned the cycle: drop the byte, no response
                        post_pend_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (!fifo_full) begin
                        ack_q       <= 1'b1;
                        post_stb_q  <= post_pend_q;
                        post_pend_q <= 1'b0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    wb_io_debug_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_con_fifo (
        .clk_i      (wb_clk_i),
        .rst_n_i    (wb_rst_n_i),
        .push_i     (fifo_push),
        .push_dat_i (fifo_push_dat),
        .pop_i      (con_ready_i),
        .head_dat_o (con_data_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (con_level_o)
    );

    assign wb_ack_o    = ack_q;
`ifdef WB_IO_DEBUG_PORT_ERR_EN
    assign wb_err_o    = err_q;
`else
    assign wb_err_o    = 1'b0;
    logic  unused_err;
    assign unused_err  = err_q;
`endif
    assign wb_rty_o    = 1'b0;
    assign wb_dat_o    = dat_q;
    assign post_code_o = post_code_q;
    assign post_stb_o  = post_stb_q;
    assign con_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_wb_io_debug_port.sv
module tb_wb_io_debug_port;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

`ifdef WB_IO_DEBUG_PORT_ERR_EN
    localparam logic UNMAP_ERR = 1'b1;
`else
    localparam logic UNMAP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   wb_adr = '0;
    logic [31:0]   wb_dat = '0;
    logic [3:0]    wb_sel = '0;
    logic          wb_we = 1'b0;
    logic          wb_cyc = 1'b0;
    logic          wb_stb = 1'b0;
    logic          con_ready = 1'b0;

    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;
    logic [7:0]    con_data_o;
    logic          con_valid_o;
    logic [7:0]    post_code_o;
    logic          post_stb_o;
    logic [LW-1:0] con_level_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] post_model = 8'h00;
    int         stb_exp    = 0;
    logic [7:0] exp_q[$];

    // Observed side effects
    int         stb_seen   = 0;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    wb_io_debug_port #(.FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wb_adr_i    (wb_adr),
        .wb_dat_i    (wb_dat),
        .wb_sel_i    (wb_sel),
        .wb_we_i     (wb_we),
        .wb_cyc_i    (wb_cyc),
        .wb_stb_i    (wb_stb),
        .wb_cti_i    (3'b000),
        .wb_bte_i    (2'b00),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .wb_err_o    (wb_err_o),
        .wb_rty_o    (wb_rty_o),
        .con_data_o  (con_data_o),
        .con_valid_o (con_valid_o),
        .con_ready_i (con_ready),
        .post_code_o (post_code_o),
        .post_stb_o  (post_stb_o),
        .con_level_o (con_level_o)
    );

    // Byte-stream logger and POST strobe counter, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && con_valid_o && con_ready) got_q.push_back(con_data_o);
        if (post_stb_o) stb_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle; returns cycles to response, read data, err flag and POST strobe seen with the response
    task automatic wb_cycle(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic we, output int lat, output logic [31:0] rdat,
                            output logic rerr, output logic rstb);
        @(posedge clk); #1;
        wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (wb_ack_o || wb_err_o) break;
        end
        rdat = wb_dat_o; rerr = wb_err_o; rstb = post_stb_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        check("resp_one_cycle", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        check("dat_zero_after", wb_dat_o, 32'd0);
    endtask

    task automatic wait_drained();
        int n = 0;
        while (con_level_o != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check("drain_level0", 32'(con_level_o), 32'd0);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         lat;
        logic [31:0] rd, d, expd;
        logic        re, st, acked;
        logic [3:0]  s;
        logic [7:0]  b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_err", 32'(wb_err_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_post", 32'(post_code_o), 32'd0);
        check("rst_stb", 32'(post_stb_o), 32'd0);
        check("rst_valid", 32'(con_valid_o), 32'd0);
        check("rst_level", 32'(con_level_o), 32'd0);
        check("rst_rty", 32'(wb_rty_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // POST write A5
        wb_cycle(32'h80, 32'h0000_00A5, 4'b0001, 1'b1, lat, rd, re, st);
        post_model = 8'hA5; stb_exp++;
        check("post_lat", 32'(lat), 32'd1);
        check("post_code", 32'(post_code_o), 32'(post_model));
        check("post_stb_ack", 32'(st), 32'd1);
        check("post_fifo", 32'(con_level_o), 32'd0);

        // Read POST word and console word
        wb_cycle(32'h80, 32'h0, 4'b1111, 1'b0, lat, rd, re, st);
        check("rd_post", rd, 32'hFFFF_FFA5);
        wb_cycle(32'hE8, 32'h0, 4'b1111, 1'b0, lat, rd, re, st);
        check("rd_con", rd, 32'hFFFF_E9FF);
        check("rd_con_lat", 32'(lat), 32'd1);

        // Console write passthrough with consumer ready
        con_ready = 1'b1;
        wb_cycle(32'hE8, 32'h0000_4800, 4'b0010, 1'b1, lat, rd, re, st);
        exp_q.push_back(8'h48);
        check("con_lat", 32'(lat), 32'd1);
        check("con_no_stb", 32'(st), 32'd0);
        wait_drained();
        compare_stream("con_pass");

        // Randomized POST and console writes, randomized lane selects
        for (int i = 0; i < 6; i++) begin
            d = $urandom; s = 4'($urandom_range(0, 15));
            wb_cycle(32'h80, d, s, 1'b1, lat, rd, re, st);
            check("rnd_post_lat", 32'(lat), 32'd1);
            check("rnd_post_err", 32'(re), 32'(UNMAP_ERR & ~s[0]));
            check("rnd_post_stb", 32'(st), 32'(s[0]));
            if (s[0]) begin post_model = d[7:0]; stb_exp++; end
            check("rnd_post_code", 32'(post_code_o), 32'(post_model));

            d = $urandom; s = 4'($urandom_range(0, 15));
            wb_cycle(32'hE8, d, s, 1'b1, lat, rd, re, st);
            check("rnd_con_lat", 32'(lat), 32'd1);
            if (s[1]) exp_q.push_back(d[15:8]);

            s = 4'($urandom_range(0, 15));
            wb_cycle(32'h80 | 32'(i[0] ? 32'h68 : 32'h0), 32'h0, s, 1'b0, lat, rd, re, st);
            expd = 32'hFFFF_FFFF;
            if (i[0] == 1'b0 && s[0]) expd[7:0] = post_model;
            if (i[0] == 1'b1 && s[1]) expd[15:8] = 8'hE9;
            check("rnd_read", rd, expd);
        end
        wait_drained();
        compare_stream("rnd_con");

        // Fill the FIFO with the consumer stalled
        con_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            wb_cycle(32'hE8, {16'h0, b, 8'h00}, 4'b0010, 1'b1, lat, rd, re, st);
            exp_q.push_back(b);
            check("fill_lat", 32'(lat), 32'd1);
        end
        check("fill_level", 32'(con_level_o), 32'(DEPTH));
        check("fill_valid", 32'(con_valid_o), 32'd1);

        // 17th byte must stall until one byte is drained
        b = 8'($urandom);
        @(posedge clk); #1;
        wb_adr = 32'hE8; wb_dat = {16'h0, b, 8'h00}; wb_sel = 4'b0010; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        acked = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) acked = 1'b1;
        end
        check("stall_no_ack", 32'(acked), 32'd0);
        check("stall_level", 32'(con_level_o), 32'(DEPTH));
        con_ready = 1'b1;
        @(posedge clk); #1;
        con_ready = 1'b0;
        lat = 0;
        while (!wb_ack_o && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        exp_q.push_back(b);
        check("stall_ack", 32'(wb_ack_o), 32'd1);
        check("stall_level_after", 32'(con_level_o), 32'(DEPTH));
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        check("stall_ack_one", 32'(wb_ack_o), 32'd0);
        con_ready = 1'b1;
        wait_drained();
        con_ready = 1'b0;
        compare_stream("fill_order");

        // Unmapped port: no side effects, ack or err
        d = $urandom;
        wb_cycle(32'h3F8, d, 4'b1111, 1'b1, lat, rd, re, st);
        check("unmap_wr_lat", 32'(lat), 32'd1);
        check("unmap_wr_err", 32'(re), 32'(UNMAP_ERR));
        check("unmap_wr_stb", 32'(st), 32'd0);
        wb_cycle(32'h3F8, 32'h0, 4'b1111, 1'b0, lat, rd, re, st);
        check("unmap_rd_lat", 32'(lat), 32'd1);
        check("unmap_rd_err", 32'(re), 32'(UNMAP_ERR));
        check("unmap_rd_dat", rd, 32'hFFFF_FFFF);
        check("unmap_post", 32'(post_code_o), 32'(post_model));
        check("unmap_level", 32'(con_level_o), 32'd0);
        check("stb_count", 32'(stb_seen), 32'(stb_exp));

        // Reset while a console write waits for space
        for (int i = 0; i < DEPTH; i++) begin
            wb_cycle(32'hE8, $urandom, 4'b0010, 1'b1, lat, rd, re, st);
        end
        @(posedge clk); #1;
        wb_adr = 32'hE8; wb_dat = 32'h0000_5A00; wb_sel = 4'b0010; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 32'(wb_ack_o), 32'd0);
        check("mid_rst_level", 32'(con_level_o), 32'd0);
        check("mid_rst_valid", 32'(con_valid_o), 32'd0);
        check("mid_rst_post", 32'(post_code_o), 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        acked = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) acked = 1'b1;
        end
        check("post_rst_no_ack", 32'(acked), 32'd0);
        check("post_rst_level", 32'(con_level_o), 32'd0);
        check("post_rst_no_pop", 32'(got_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
